pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall sequencer for the 5-stage pipeline. It watches the ID and EX stages and drives the stall/flush controls of the IF/ID pipeline register, the PC hold, ID/EX bubble insertion and EX hold. It sequences load-use stalls, taken-branch flushes, instruction-memory wait cycles and multi-cycle EX operations (mul/div). It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- WIDTH_R, 5, register index width
- MC_LAT, 4, total EX occupancy in cycles of a multi-cycle op; legal range 1..16
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- id_rs  in  WIDTH_R  source register 1 of the instruction in ID
- id_rt  in  WIDTH_R  source register 2 of the instruction in ID
- id_rs_used  in  1  ID instruction reads id_rs
- id_rt_used  in  1  ID instruction reads id_rt
- idex_memread  in  1  instruction in EX is a load
- idex_rd  in  WIDTH_R  destination register of the instruction in EX
- id_mc_start  in  1  instruction in ID is a multi-cycle op
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- imem_ready  in  1  instruction memory returns valid data this cycle
- stall_ifid  out  1  hold IF/ID register (drives its stall_ctrl)
- flush_ifid  out  1  load NOP into IF/ID (drives its flush_ctrl)
- pc_hold  out  1  PC keeps its value
- bubble_idex  out  1  zero control fields entering ID/EX
- ex_hold  out  1  ID/EX and EX stage hold contents
- mc_busy  out  1  FSM is in MC
- stall_cnt  out  16  stall cycles seen, saturating

## Operation
- FSM states are RUN and MC. There is also a 4-bit down-counter `cnt`.
- Outputs are Mealy, decoded from the state and the current inputs. While rst=1, all 1-bit outputs are 0.
- Load-use condition (lu) = idex_memread & (idex_rd != 0) & ((id_rs_used & id_rs==idex_rd) | (id_rt_used & id_rt==idex_rd)).
- RUN evaluates the following in priority order:
  1. ex_branch_taken: flush_ifid=1, bubble_idex=1, stall_ifid=0, pc_hold=0. lu, id_mc_start and imem_ready are ignored. Stay in RUN.
  2. lu: stall_ifid=1, pc_hold=1, bubble_idex=1. Stay in RUN. Re-evaluation happens every cycle; no extra state is used.
  3. id_mc_start: no stall outputs this cycle. If MC_LAT>1, go to MC with cnt=MC_LAT-1. If MC_LAT==1, stay in RUN.
  4. !imem_ready: pc_hold=1, flush_ifid=1, stall_ifid=0. Stay in RUN.
  5. Otherwise all control outputs are 0.
- MC:
  - Outputs: stall_ifid=1, pc_hold=1, ex_hold=1, mc_busy=1, flush_ifid=0, bubble_idex=0.
  - ex_branch_taken, lu, id_mc_start and imem_ready are ignored.
  - cnt decrements each cycle. Return to RUN on the edge where cnt==1.
- stall_ifid and flush_ifid are never both 1.
- stall_cnt: +1 on every edge where stall_ifid=1 and rst=0. It saturates at 16'hFFFF.

## Timing
- Reset values: state=RUN, cnt=0, stall_cnt=0. All 1-bit outputs read 0 in the cycle after the reset edge, given idle inputs.
- Reset asserted mid-MC: the FSM is in RUN on the next edge and the stall outputs drop immediately, since they are gated by rst.
- Load-use adds exactly 1 stall cycle per hazard. The following cycle has idex_memread=0 from the injected bubble.
- Multi-cycle op: id_mc_start=1 at cycle T in RUN. Cycles T+1 .. T+MC_LAT-1 are in MC with stalls asserted. Cycle T+MC_LAT is in RUN. That gives MC_LAT-1 stall cycles in total.
- Branch flush: outputs are asserted in the same cycle as ex_branch_taken. There is 1 flush cycle per taken branch.
- imem wait lasts as many cycles as imem_ready=0. Each such cycle has pc_hold=1 and flush_ifid=1.
- stall_cnt updates one edge after the cycle being counted.

## Test plan
- Load-use: idex_memread=1, idex_rd=5, id_rs=5, id_rs_used=1 for one cycle -> stall_ifid=pc_hold=bubble_idex=1 for 1 cycle; stall_cnt=1 afterwards. The same stimulus with idex_rd=0 -> no stall.
- Branch over hazard: ex_branch_taken=1 together with the load-use stimulus -> flush_ifid=1, bubble_idex=1, stall_ifid=0, pc_hold=0; stall_cnt unchanged.
- Multi-cycle op, MC_LAT=4: id_mc_start pulse at T -> mc_busy, ex_hold and stall_ifid high in T+1..T+3 and low at T+4; stall_cnt=3. ex_branch_taken pulsed at T+2 is ignored.
- imem wait: imem_ready=0 for 3 cycles -> pc_hold=1 and flush_ifid=1 for exactly those 3 cycles; stall_ifid=0.
- Reset mid-MC: rst=1 at T+2 of an MC_LAT=8 op -> all outputs 0 during reset; mc_busy=0 and stall_cnt=0 after release.
- Saturation: hold the lu stimulus for 65540 cycles -> stall_cnt stops at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between pipeline datapath and pipe_hazard_ctrl.
// Latency: wires only, no state.
// Backpressure: none; master drives stage info, slave returns stall/flush controls.
interface pipe_hazard_ctrl_if #(
  parameter int WIDTH_R = 5
);
  logic [WIDTH_R-1:0] id_rs;
  logic [WIDTH_R-1:0] id_rt;
  logic               id_rs_used;
  logic               id_rt_used;
  logic               idex_memread;
  logic [WIDTH_R-1:0] idex_rd;
  logic               id_mc_start;
  logic               ex_branch_taken;
  logic               imem_ready;
  logic               stall_ifid;
  logic               flush_ifid;
  logic               pc_hold;
  logic               bubble_idex;
  logic               ex_hold;
  logic               mc_busy;
  logic [15:0]        stall_cnt;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, idex_memread, idex_rd,
           id_mc_start, ex_branch_taken, imem_ready,
    input  stall_ifid, flush_ifid, pc_hold, bubble_idex, ex_hold, mc_busy,
           stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, idex_memread, idex_rd,
           id_mc_start, ex_branch_taken, imem_ready,
    output stall_ifid, flush_ifid, pc_hold, bubble_idex, ex_hold, mc_busy,
           stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer: load-use stall, branch flush, imem wait, multi-cycle EX hold.
// Latency: controls are combinational from state+inputs; stall_cnt lags by one edge.
// Backpressure: none accepted; this block is the source of pipeline stalls.
module pipe_hazard_ctrl #(
  parameter int WIDTH_R = 5,
  parameter int MC_LAT  = 4
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN = 1'b0, MC = 1'b1} state_e;

  localparam logic [WIDTH_R-1:0] REG_ZERO    = '0;
  localparam logic [3:0]         MC_CNT_INIT = 4'(MC_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        lu;
  logic        stall_ifid, flush_ifid, pc_hold, bubble_idex, ex_hold, mc_busy;

  // Load in EX writing a register that the ID instruction actually reads (r0 never hazards).
  always_comb begin
    lu = hz.idex_memread && (hz.idex_rd != REG_ZERO) &&
         ((hz.id_rs_used && (hz.id_rs == hz.idex_rd)) ||
          (hz.id_rt_used && (hz.id_rt == hz.idex_rd)));
  end

  // Next state and Mealy controls; everything forced low while reset is asserted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    pc_hold     = 1'b0;
    bubble_idex = 1'b0;
    ex_hold     = 1'b0;
    mc_busy     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (hz.ex_branch_taken) begin
            // Wrong-path instruction in ID is squashed; fetch redirect proceeds.
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end else if (lu) begin
            // One-cycle stall; the injected bubble clears idex_memread next cycle.
            stall_ifid  = 1'b1;
            pc_hold     = 1'b1;
            bubble_idex = 1'b1;
          end else if (hz.id_mc_start) begin
            // The op enters EX this cycle; the hold starts from the next one.
            if (MC_LAT > 1) begin
              state_d = MC;
              cnt_d   = MC_CNT_INIT;
            end
          end else if (!hz.imem_ready) begin
            // Fetch not back yet: keep the PC and feed a NOP into IF/ID.
            pc_hold    = 1'b1;
            flush_ifid = 1'b1;
          end
        end
        MC: begin
          // Whole front end frozen while EX finishes; other hazards wait.
          stall_ifid = 1'b1;
          pc_hold    = 1'b1;
          ex_hold    = 1'b1;
          mc_busy    = 1'b1;
          cnt_d      = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating count of cycles in which IF/ID was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_ifid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State, down-counter and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_ifid  = stall_ifid;
  assign hz.flush_ifid  = flush_ifid;
  assign hz.pc_hold     = pc_hold;
  assign hz.bubble_idex = bubble_idex;
  assign hz.ex_hold     = ex_hold;
  assign hz.mc_busy     = mc_busy;
  assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (MC_LAT=4 and 8) share one stimulus stream.
// Latency: checks sampled on the falling edge, model advanced after each rising edge.
// Backpressure: n/a; stimulus is driven every cycle.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, idex_rd;
  logic       id_rs_used, id_rt_used, idex_memread, id_mc_start, ex_branch_taken, imem_ready;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.WIDTH_R(5)) if4 ();
  pipe_hazard_ctrl_if #(.WIDTH_R(5)) if8 ();

  assign if4.id_rs = id_rs;               assign if8.id_rs = id_rs;
  assign if4.id_rt = id_rt;               assign if8.id_rt = id_rt;
  assign if4.id_rs_used = id_rs_used;     assign if8.id_rs_used = id_rs_used;
  assign if4.id_rt_used = id_rt_used;     assign if8.id_rt_used = id_rt_used;
  assign if4.idex_memread = idex_memread; assign if8.idex_memread = idex_memread;
  assign if4.idex_rd = idex_rd;           assign if8.idex_rd = idex_rd;
  assign if4.id_mc_start = id_mc_start;   assign if8.id_mc_start = id_mc_start;
  assign if4.ex_branch_taken = ex_branch_taken;
  assign if8.ex_branch_taken = ex_branch_taken;
  assign if4.imem_ready = imem_ready;     assign if8.imem_ready = imem_ready;

  pipe_hazard_ctrl #(.WIDTH_R(5), .MC_LAT(4)) dut4 (.clk(clk), .rst(rst), .hz(if4.slave));
  pipe_hazard_ctrl #(.WIDTH_R(5), .MC_LAT(8)) dut8 (.clk(clk), .rst(rst), .hz(if8.slave));

  // Observed controls packed as {stall_ifid, flush_ifid, pc_hold, bubble_idex, ex_hold, mc_busy}.
  logic [5:0]  o [2];
  logic [15:0] c [2];
  assign o[0] = {if4.stall_ifid, if4.flush_ifid, if4.pc_hold, if4.bubble_idex, if4.ex_hold, if4.mc_busy};
  assign o[1] = {if8.stall_ifid, if8.flush_ifid, if8.pc_hold, if8.bubble_idex, if8.ex_hold, if8.mc_busy};
  assign c[0] = if4.stall_cnt;
  assign c[1] = if8.stall_cnt;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: remaining multi-cycle stall cycles and stall count per instance.
  int         ml [2] = '{0, 0};
  int         sc [2] = '{0, 0};
  logic [5:0] e  [2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic bit model_lu();
    return idex_memread && (idex_rd != 5'd0) &&
           ((id_rs_used && id_rs == idex_rd) || (id_rt_used && id_rt == idex_rd));
  endfunction

  task automatic model_eval();
    for (int i = 0; i < 2; i++) begin
      if (rst)                  e[i] = 6'b000000;
      else if (ml[i] > 0)       e[i] = 6'b101011;
      else if (ex_branch_taken) e[i] = 6'b010100;
      else if (model_lu())      e[i] = 6'b101100;
      else if (id_mc_start)     e[i] = 6'b000000;
      else if (!imem_ready)     e[i] = 6'b011000;
      else                      e[i] = 6'b000000;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ml[i] = 0;
        sc[i] = 0;
      end else begin
        if (e[i][5] && sc[i] < 65535) sc[i]++;
        if (ml[i] > 0) ml[i]--;
        else if (!ex_branch_taken && !model_lu() && id_mc_start) ml[i] = lat_of(i) - 1;
      end
    end
  endtask

  task automatic half();
    model_eval();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; idex_rd = 5'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; idex_memread = 1'b0;
    id_mc_start = 1'b0; ex_branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic lu_stim();
    idle();
    idex_memread = 1'b1; idex_rd = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) rst = 1'b0;
      half();
      for (int i = 0; i < 2; i++) begin
        n_run++;
        if (o[i] !== e[i] || c[i] !== 16'(sc[i])) begin
          n_fail++;
          $display("FAIL reset inst%0d cyc%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, k, o[i], c[i], e[i], sc[i]);
        end
      end
      if (k == 2) begin
        n_run++;
        if (o[0] !== 6'b0 || c[0] !== 16'd0) begin
          n_fail++;
          $display("FAIL reset_idle outs=%b cnt=%0d expected outs=000000 cnt=0", o[0], c[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    int base = sc[0];
    for (int k = 0; k < 3; k++) begin
      if (k == 0) lu_stim();
      else if (k == 1) idle();
      else begin lu_stim(); idex_rd = 5'd0; id_rs = 5'd0; end
      half();
      for (int i = 0; i < 2; i++) begin
        n_run++;
        if (o[i] !== e[i] || c[i] !== 16'(sc[i])) begin
          n_fail++;
          $display("FAIL load_use inst%0d cyc%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, k, o[i], c[i], e[i], sc[i]);
        end
      end
      n_run++;
      if ((k == 0 && o[0] !== 6'b101100) || (k != 0 && o[0] !== 6'b000000) ||
          (k == 1 && c[0] !== 16'(base + 1))) begin
        n_fail++;
        $display("FAIL load_use_fixed cyc%0d outs=%b cnt=%0d base=%0d", k, o[0], c[0], base);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_branch_over_hazard();
    int base = sc[0];
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin lu_stim(); ex_branch_taken = 1'b1; end
      else idle();
      half();
      for (int i = 0; i < 2; i++) begin
        n_run++;
        if (o[i] !== e[i] || c[i] !== 16'(sc[i])) begin
          n_fail++;
          $display("FAIL branch inst%0d cyc%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, k, o[i], c[i], e[i], sc[i]);
        end
      end
      n_run++;
      if ((k == 0 && o[0] !== 6'b010100) || (k == 1 && c[0] !== 16'(base))) begin
        n_fail++;
        $display("FAIL branch_fixed cyc%0d outs=%b cnt=%0d expected cnt=%0d", k, o[0], c[0], base);
      end
      tick();
    end
  endtask

  task automatic test_multicycle();
    int base = sc[0];
    for (int k = 0; k < 10; k++) begin
      idle();
      id_mc_start     = (k == 0);
      ex_branch_taken = (k == 2);
      half();
      for (int i = 0; i < 2; i++) begin
        n_run++;
        if (o[i] !== e[i] || c[i] !== 16'(sc[i])) begin
          n_fail++;
          $display("FAIL multicycle inst%0d cyc%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, k, o[i], c[i], e[i], sc[i]);
        end
      end
      if (k >= 1 && k <= 4) begin
        n_run++;
        if ((k < 4 && o[0] !== 6'b101011) || (k == 4 && (o[0] !== 6'b000000 || c[0] !== 16'(base + 3)))) begin
          n_fail++;
          $display("FAIL multicycle_fixed cyc%0d outs=%b cnt=%0d base=%0d", k, o[0], c[0], base);
        end
      end
      tick();
    end
  endtask

  task automatic test_imem_wait();
    for (int k = 0; k < 4; k++) begin
      idle();
      imem_ready = (k == 3);
      half();
      for (int i = 0; i < 2; i++) begin
        n_run++;
        if (o[i] !== e[i] || c[i] !== 16'(sc[i])) begin
          n_fail++;
          $display("FAIL imem_wait inst%0d cyc%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, k, o[i], c[i], e[i], sc[i]);
        end
      end
      n_run++;
      if ((k < 3 && o[0] !== 6'b011000) || (k == 3 && o[0] !== 6'b000000)) begin
        n_fail++;
        $display("FAIL imem_wait_fixed cyc%0d outs=%b", k, o[0]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_mc();
    for (int k = 0; k < 5; k++) begin
      idle();
      id_mc_start = (k == 0);
      rst         = (k == 2 || k == 3);
      half();
      for (int i = 0; i < 2; i++) begin
        n_run++;
        if (o[i] !== e[i] || c[i] !== 16'(sc[i])) begin
          n_fail++;
          $display("FAIL reset_mid_mc inst%0d cyc%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, k, o[i], c[i], e[i], sc[i]);
        end
      end
      n_run++;
      if ((k == 1 && o[1] !== 6'b101011) || ((k == 2 || k == 3) && o[1] !== 6'b000000) ||
          (k == 4 && (o[1][0] !== 1'b0 || c[1] !== 16'd0))) begin
        n_fail++;
        $display("FAIL reset_mid_mc_fixed cyc%0d outs=%b cnt=%0d", k, o[1], c[1]);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      idex_rd         = 5'($urandom_range(0, 3));
      id_rs_used      = 1'($urandom_range(0, 1));
      id_rt_used      = 1'($urandom_range(0, 1));
      idex_memread    = 1'($urandom_range(0, 1));
      id_mc_start     = ($urandom_range(0, 5) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      imem_ready      = ($urandom_range(0, 4) != 0);
      rst             = ($urandom_range(0, 99) == 0);
      half();
      for (int i = 0; i < 2; i++) begin
        n_run++;
        if (o[i] !== e[i] || c[i] !== 16'(sc[i])) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, k, o[i], c[i], e[i], sc[i]);
        end
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_saturation();
    rst = 1'b1; idle();
    half(); tick();
    rst = 1'b0;
    lu_stim();
    for (int k = 0; k < 65540; k++) begin
      half(); tick();
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 1) idle();
      half();
      for (int i = 0; i < 2; i++) begin
        n_run++;
        if (o[i] !== e[i] || c[i] !== 16'(sc[i]) || c[i] !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL saturation inst%0d cyc%0d outs=%b cnt=%0d expected outs=%b cnt=65535", i, k, o[i], c[i], e[i]);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_branch_over_hazard();
    test_multicycle();
    test_imem_wait();
    test_reset_mid_mc();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
